// File: rtl/fetch_unit.sv
// Instruction fetch unit.
//
// Holds the fetch PC, issues single-word reads to instruction memory and
// presents the returned word to decode through a valid/ready register.
// Fetch alternates REQ (memory read) and HOLD (word waiting for decode), so
// with zero-wait memory and decode always ready it issues one instruction
// every two cycles.
//
// Ports:
//   clk_i          clock, rising edge
//   rst_ni         asynchronous active-low reset
//   pc_o           current fetch PC (feeds the external incrementer)
//   next_pc_i      incrementer result (pc_o + 1), used for sequential advance
//   redirect_i     branch/jump taken strobe, highest priority
//   redirect_pc_i  redirect target, valid with redirect_i
//   imem_req_o     instruction memory read request
//   imem_addr_o    read address, always equal to pc_o
//   imem_ack_i     imem_rdata_i valid this cycle (ignored unless requesting)
//   imem_rdata_i   instruction word from memory
//   ir_o           instruction register presented to decode
//   ir_valid_o     ir_o holds an unconsumed instruction
//   ir_ready_i     decode accept
module fetch_unit #(
   parameter int unsigned   W        = 16,
   parameter logic [W-1:0] RESET_PC = '0
) (
   input  logic         clk_i,
   input  logic         rst_ni,
   output logic [W-1:0] pc_o,
   input  logic [W-1:0] next_pc_i,
   input  logic         redirect_i,
   input  logic [W-1:0] redirect_pc_i,
   output logic         imem_req_o,
   output logic [W-1:0] imem_addr_o,
   input  logic         imem_ack_i,
   input  logic [W-1:0] imem_rdata_i,
   output logic [W-1:0] ir_o,
   output logic         ir_valid_o,
   input  logic         ir_ready_i
);

   typedef enum logic [1:0] {
      StIdle = 2'b00,
      StReq  = 2'b01,
      StHold = 2'b10
   } state_e;

   state_e       state_q, state_d;
   logic [W-1:0] pc_q, pc_d;
   logic [W-1:0] ir_q, ir_d;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= StIdle;
         pc_q    <= RESET_PC;
         ir_q    <= '0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         ir_q    <= ir_d;
      end
   end

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      ir_d    = ir_q;
      unique case (state_q)
         // Redirect is deliberately ignored here: nothing is in flight yet.
         StIdle: state_d = StReq;
         StReq: begin
            if (redirect_i) begin
               // Any word returned this cycle belongs to the squashed path.
               pc_d    = redirect_pc_i;
               state_d = StReq;
            end else if (imem_ack_i) begin
               ir_d    = imem_rdata_i;
               state_d = StHold;
            end
         end
         StHold: begin
            // A coincident ir_ready still completes the transfer; only the
            // PC source changes.
            if (redirect_i) begin
               pc_d    = redirect_pc_i;
               state_d = StReq;
            end else if (ir_ready_i) begin
               pc_d    = next_pc_i;
               state_d = StReq;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // All outputs decode registered state only, so no input reaches them
   // combinationally.
   assign pc_o        = pc_q;
   assign imem_addr_o = pc_q;
   assign ir_o        = ir_q;
   assign imem_req_o  = (state_q == StReq);
   assign ir_valid_o  = (state_q == StHold);

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

   localparam int unsigned W = 16;

   logic         clk = 1'b0;
   logic         rst_n;
   logic [W-1:0] pc;
   logic [W-1:0] next_pc;
   logic         redirect;
   logic [W-1:0] redirect_pc;
   logic         imem_req;
   logic [W-1:0] imem_addr;
   logic         imem_ack;
   logic [W-1:0] imem_rdata;
   logic [W-1:0] ir;
   logic         ir_valid;
   logic         ir_ready;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   // External incrementer as it would sit beside the fetch unit.
   assign next_pc = pc + 16'd1;

   fetch_unit #(
      .W        (W),
      .RESET_PC (16'h0000)
   ) dut (
      .clk_i         (clk),
      .rst_ni        (rst_n),
      .pc_o          (pc),
      .next_pc_i     (next_pc),
      .redirect_i    (redirect),
      .redirect_pc_i (redirect_pc),
      .imem_req_o    (imem_req),
      .imem_addr_o   (imem_addr),
      .imem_ack_i    (imem_ack),
      .imem_rdata_i  (imem_rdata),
      .ir_o          (ir),
      .ir_valid_o    (ir_valid),
      .ir_ready_i    (ir_ready)
   );

   typedef struct {
      logic        ack;
      logic [15:0] rdata;
      logic        ready;
      logic        redir;
      logic [15:0] rpc;
      logic        exp_req;
      logic [15:0] exp_addr;
      logic [15:0] exp_ir;
      logic        exp_valid;
   } vec_t;

   localparam int NV = 29;
   vec_t vecs [NV];

   function automatic vec_t mk(input logic ack, input logic [15:0] rdata, input logic ready,
                               input logic redir, input logic [15:0] rpc, input logic exp_req,
                               input logic [15:0] exp_addr, input logic [15:0] exp_ir,
                               input logic exp_valid);
      vec_t v;
      v.ack = ack; v.rdata = rdata; v.ready = ready; v.redir = redir; v.rpc = rpc;
      v.exp_req = exp_req; v.exp_addr = exp_addr; v.exp_ir = exp_ir; v.exp_valid = exp_valid;
      return v;
   endfunction

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic check_outs(input string tag, input logic exp_req, input logic [15:0] exp_addr,
                             input logic [15:0] exp_ir, input logic exp_valid);
      check({tag, ".imem_req"}, {15'd0, imem_req}, {15'd0, exp_req});
      check({tag, ".imem_addr"}, imem_addr, exp_addr);
      check({tag, ".pc"}, pc, exp_addr);
      check({tag, ".ir"}, ir, exp_ir);
      check({tag, ".ir_valid"}, {15'd0, ir_valid}, {15'd0, exp_valid});
   endtask

   // Drive inputs, take one rising edge, sample 2 time units later.
   task automatic step(input logic ack, input logic [15:0] rdata, input logic ready,
                       input logic redir, input logic [15:0] rpc);
      imem_ack    = ack;
      imem_rdata  = rdata;
      ir_ready    = ready;
      redirect    = redir;
      redirect_pc = rpc;
      @(posedge clk);
      #2;
   endtask

   initial begin
      // ack rdata ready redir rpc | req addr ir valid
      // Sequential fetch 0,1,2,3 with zero-wait memory.
      vecs[0]  = mk(0, 16'h0000, 1, 0, 16'h0000, 1, 16'h0000, 16'h0000, 0);
      vecs[1]  = mk(1, 16'hA000, 1, 0, 16'h0000, 0, 16'h0000, 16'hA000, 1);
      vecs[2]  = mk(0, 16'h0000, 1, 0, 16'h0000, 1, 16'h0001, 16'hA000, 0);
      vecs[3]  = mk(1, 16'hA001, 1, 0, 16'h0000, 0, 16'h0001, 16'hA001, 1);
      vecs[4]  = mk(0, 16'h0000, 1, 0, 16'h0000, 1, 16'h0002, 16'hA001, 0);
      vecs[5]  = mk(1, 16'hA002, 1, 0, 16'h0000, 0, 16'h0002, 16'hA002, 1);
      vecs[6]  = mk(0, 16'h0000, 1, 0, 16'h0000, 1, 16'h0003, 16'hA002, 0);
      vecs[7]  = mk(1, 16'hA003, 1, 0, 16'h0000, 0, 16'h0003, 16'hA003, 1);
      vecs[8]  = mk(0, 16'h0000, 1, 0, 16'h0000, 1, 16'h0004, 16'hA003, 0);
      vecs[9]  = mk(1, 16'hA004, 1, 0, 16'h0000, 0, 16'h0004, 16'hA004, 1);
      vecs[10] = mk(0, 16'h0000, 1, 0, 16'h0000, 1, 16'h0005, 16'hA004, 0);
      // Ack delayed 3 cycles at pc 5: request held 4 cycles in total.
      vecs[11] = mk(0, 16'h1111, 1, 0, 16'h0000, 1, 16'h0005, 16'hA004, 0);
      vecs[12] = mk(0, 16'h2222, 1, 0, 16'h0000, 1, 16'h0005, 16'hA004, 0);
      vecs[13] = mk(0, 16'h3333, 1, 0, 16'h0000, 1, 16'h0005, 16'hA004, 0);
      vecs[14] = mk(1, 16'hB005, 0, 0, 16'h0000, 0, 16'h0005, 16'hB005, 1);
      // Decode stalls 5 cycles; stray acks must be ignored.
      vecs[15] = mk(1, 16'hFFFF, 0, 0, 16'h0000, 0, 16'h0005, 16'hB005, 1);
      vecs[16] = mk(1, 16'hFFFF, 0, 0, 16'h0000, 0, 16'h0005, 16'hB005, 1);
      vecs[17] = mk(0, 16'hFFFF, 0, 0, 16'h0000, 0, 16'h0005, 16'hB005, 1);
      vecs[18] = mk(1, 16'hFFFF, 0, 0, 16'h0000, 0, 16'h0005, 16'hB005, 1);
      vecs[19] = mk(0, 16'hFFFF, 0, 0, 16'h0000, 0, 16'h0005, 16'hB005, 1);
      vecs[20] = mk(0, 16'h0000, 1, 0, 16'h0000, 1, 16'h0006, 16'hB005, 0);
      // Redirect with coincident ack: data discarded, target fetched next.
      vecs[21] = mk(1, 16'hDEAD, 1, 1, 16'h0040, 1, 16'h0040, 16'hB005, 0);
      vecs[22] = mk(1, 16'hC040, 1, 0, 16'h0000, 0, 16'h0040, 16'hC040, 1);
      // Redirect with coincident transfer: pc takes target, not next_pc.
      vecs[23] = mk(0, 16'h0000, 1, 1, 16'hFFFF, 1, 16'hFFFF, 16'hC040, 0);
      vecs[24] = mk(1, 16'hCFFF, 1, 0, 16'h0000, 0, 16'hFFFF, 16'hCFFF, 1);
      // Transfer at FFFF wraps to 0 and fetching continues.
      vecs[25] = mk(0, 16'h0000, 1, 0, 16'h0000, 1, 16'h0000, 16'hCFFF, 0);
      vecs[26] = mk(1, 16'hD000, 1, 0, 16'h0000, 0, 16'h0000, 16'hD000, 1);
      // Redirect in HOLD without ready.
      vecs[27] = mk(0, 16'h0000, 0, 1, 16'h0010, 1, 16'h0010, 16'hD000, 0);
      vecs[28] = mk(1, 16'hD010, 0, 0, 16'h0000, 0, 16'h0010, 16'hD010, 1);

      rst_n       = 1'b0;
      imem_ack    = 1'b0;
      imem_rdata  = '0;
      ir_ready    = 1'b0;
      redirect    = 1'b0;
      redirect_pc = '0;

      #2;
      check_outs("reset", 0, 16'h0000, 16'h0000, 0);
      @(posedge clk);
      #2;
      rst_n = 1'b1;

      for (int i = 0; i < NV; i++) begin
         step(vecs[i].ack, vecs[i].rdata, vecs[i].ready, vecs[i].redir, vecs[i].rpc);
         check_outs($sformatf("vec%0d", i), vecs[i].exp_req, vecs[i].exp_addr,
                    vecs[i].exp_ir, vecs[i].exp_valid);
      end

      // Reset pulsed between edges while in HOLD: outputs clear before the next edge.
      #3;
      rst_n = 1'b0;
      #1;
      check_outs("async_rst", 0, 16'h0000, 16'h0000, 0);
      @(posedge clk);
      #2;
      check_outs("rst_held", 0, 16'h0000, 16'h0000, 0);
      rst_n = 1'b1;

      // Redirect in IDLE is ignored; first request goes to RESET_PC.
      step(1, 16'h9999, 1, 1, 16'h0077);
      check_outs("idle_redir", 1, 16'h0000, 16'h0000, 0);
      step(1, 16'hE000, 1, 0, 16'h0000);
      check_outs("restart", 0, 16'h0000, 16'hE000, 1);
      step(0, 16'h0000, 1, 0, 16'h0000);
      check_outs("restart_adv", 1, 16'h0001, 16'hE000, 0);

      // Reset mid-request with a pending ack: no ir load, no pc advance.
      imem_ack   = 1'b1;
      imem_rdata = 16'h1234;
      #3;
      rst_n = 1'b0;
      @(posedge clk);
      #2;
      check_outs("rst_midreq", 0, 16'h0000, 16'h0000, 0);
      rst_n = 1'b1;
      step(0, 16'h0000, 1, 0, 16'h0000);
      check_outs("rst_midreq_rel", 1, 16'h0000, 16'h0000, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 16'h0000, SHALL be the PC value loaded on reset.
REQ-002 Parameter W, default 16, SHALL be the PC/instruction width; all 16-bit ports below SHALL be W bits.
REQ-003 clk  input  1  SHALL be the single clock; all state SHALL update on its rising edge.
REQ-004 rst_n  input  1  SHALL be the reset: asynchronous, active-low.
REQ-005 pc  output  16  SHALL be the current fetch PC, driven directly from the PC register, and SHALL feed the PC incrementer's oldPC input.
REQ-006 next_pc  input  16  SHALL be the incrementer's result (pc+1), used for sequential advance.
REQ-007 redirect  input  1  SHALL be the branch/jump taken strobe, active-high.
REQ-008 redirect_pc  input  16  SHALL be the redirect target, valid when redirect=1.
REQ-009 imem_req  output  1  SHALL be the instruction memory read request.
REQ-010 imem_addr  output  16  SHALL be the read address and SHALL equal pc at all times.
REQ-011 imem_ack  input  1  SHALL indicate imem_rdata is valid for imem_addr this cycle; it is ignored when imem_req=0.
REQ-012 imem_rdata  input  16  SHALL be the instruction word returned by memory.
REQ-013 ir  output  16  SHALL be the instruction register presented to decode.
REQ-014 ir_valid  output  1  SHALL indicate ir holds an instruction not yet consumed.
REQ-015 ir_ready  input  1  SHALL be the decode accept; a transfer occurs on a cycle with ir_valid=1 and ir_ready=1.

Function
REQ-016 The block SHALL implement states IDLE, REQ and HOLD, with imem_req=1 only in REQ and ir_valid=1 only in HOLD.
REQ-017 IDLE SHALL advance to REQ on the first rising edge after rst_n deasserts.
REQ-018 REQ with imem_ack=1 and redirect=0 SHALL load ir<=imem_rdata and go to HOLD; with imem_ack=0 it SHALL stay in REQ with pc unchanged.
REQ-019 HOLD with ir_ready=1 and redirect=0 SHALL load pc<=next_pc and go to REQ; with ir_ready=0 it SHALL hold ir, ir_valid and pc stable.
REQ-020 Fetch-to-issue latency SHALL be 1 cycle: ir_valid rises on the edge that samples imem_ack=1.
REQ-021 Sustained throughput SHALL be one instruction per 2 cycles with zero-wait memory and ir_ready tied high.
REQ-022 redirect=1 in REQ or HOLD SHALL have priority over all other events: pc<=redirect_pc, next state REQ, ir_valid<=0.
REQ-023 redirect=1 coincident with imem_ack=1 SHALL discard imem_rdata; ir SHALL keep its prior value.
REQ-024 redirect=1 coincident with an ir_ready transfer in HOLD SHALL still count as a transfer, and pc SHALL take redirect_pc, not next_pc.
REQ-025 redirect in IDLE SHALL be ignored.
REQ-026 The memory interface SHALL allow imem_addr to change while a request is unacknowledged (no outstanding-transaction tracking).
REQ-027 PC arithmetic SHALL be modulo 2^16; next_pc from 16'hFFFF is 16'h0000 and SHALL be loaded without error.
REQ-028 Outputs pc, imem_req, imem_addr, ir and ir_valid SHALL have no combinational path from imem_ack, imem_rdata, ir_ready, redirect or redirect_pc.

Reset
REQ-029 rst_n=0 SHALL immediately force state=IDLE, pc=RESET_PC, ir=16'h0000, ir_valid=0 and imem_req=0, independent of clk.
REQ-030 Reset asserted mid-request or mid-hold SHALL abandon the transaction with no ir update and no pc advance.
REQ-031 After reset release, imem_req SHALL first assert one cycle later, with imem_addr=RESET_PC.

Verification
REQ-032 The bench SHALL cover: reset release, zero-wait memory, ir_ready=1, next_pc=pc+1 -> imem_addr sequence 0,1,2,3 with ir_valid every other cycle.
REQ-033 The bench SHALL cover: ack delayed 3 cycles at pc=16'h0005 -> imem_req and imem_addr=16'h0005 held for 4 cycles, then ir=rdata and ir_valid=1.
REQ-034 The bench SHALL cover: ir_ready=0 for 5 cycles in HOLD -> ir, ir_valid=1 and pc stable, and imem_req=0 throughout.
REQ-035 The bench SHALL cover: redirect=1 with redirect_pc=16'h0040 in the same cycle as imem_ack=1 -> ir unchanged, ir_valid=0, next imem_addr=16'h0040.
REQ-036 The bench SHALL cover: pc=16'hFFFF transfer -> pc wraps to 16'h0000 and fetch continues.
REQ-037 The bench SHALL cover: rst_n pulsed low between clock edges while in HOLD -> outputs reach reset values before the next edge, and the sequence restarts at RESET_PC.
